data_mem_loader: RTL and testbench

DATA_MEM_LOADER -- requirements
Module: data_mem_loader

---
 rtl/data_mem_loader.sv | 110 +++++++++++
 tb/tb_data_mem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_loader.sv
// Streams a block of words into the data cache from the top of data memory downwards,
// holding the CPU in reset while the load runs.
module data_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd4092,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  count,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        mem_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_input_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic [9:0]  words_written,
    output logic [1:0]  state_dbg
);

    // Handshake: a word moves on the rising edge where in_valid and in_ready are both 1;
    // in_ready is high only while waiting for data, and in_valid may be held high freely.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [9:0]  count_q, count_d;
    logic [9:0]  words_q, words_d;
    logic [9:0]  words_inc;

    assign words_inc = words_q + 10'd1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        words_d = words_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != 10'd0) begin
                        count_d = count;
                        addr_d  = BASE_ADDR;
                        words_d = 10'd0;
                        state_d = WAIT_DATA;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT_DATA: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q - ADDR_STEP;
                words_d = words_inc;
                state_d = (words_inc == count_q) ? DONE : WAIT_DATA;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            data_q  <= 32'd0;
            count_q <= 10'd0;
            words_q <= 10'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            words_q <= words_d;
        end
    end

    // Every control output is a pure decode of the state flop, so none can glitch on inputs.
    assign in_ready         = (state_q == WAIT_DATA);
    assign mem_enable       = (state_q == WRITE);
    assign mem_write_enable = (state_q == WRITE);
    assign busy             = (state_q != IDLE);
    assign cpu_hold         = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign mem_address      = addr_q;
    assign mem_input_data   = data_q;
    assign words_written    = words_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_data_mem_loader.sv
// Bench for data_mem_loader: scoreboard of expected (address, data) writes, checked
// against a behavioural model of the data cache wrapper.
module tb_data_mem_loader;

    localparam logic [31:0] BASE = 32'd4092;
    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_enable;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_input_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [9:0]  words_written;
    logic [1:0]  state_dbg;

    data_mem_loader #(.BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .count            (count),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .mem_enable       (mem_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_input_data   (mem_input_data),
        .cpu_hold         (cpu_hold),
        .busy             (busy),
        .done             (done),
        .words_written    (words_written),
        .state_dbg        (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- scoreboard and memory model ----------------
    logic [63:0] exp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    int          k = 0;
    int          load_writes = 0;
    int          done_cnt = 0;
    int          last_wr_cyc = 0;
    logic [31:0] last_addr = 32'd0;
    bit          chk_rate = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_enable) begin
            logic [63:0] e;
            check("write_enable", mem_write_enable, 1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", mem_address, 64'hffff_ffff_ffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", mem_address, e[63:32]);
                check("write_data", mem_input_data, e[31:0]);
            end
            if (chk_rate && load_writes > 0) check("write_spacing", cyc - last_wr_cyc, 2);
            mem_model[mem_address] = mem_input_data;
            last_addr   = mem_address;
            last_wr_cyc = cyc;
            load_writes++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [9:0] c);
        @(negedge clk);
        start = 1'b1;
        count = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        load_writes = 0;
    endtask

    task automatic feed(input logic [31:0] d, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            n = 0;
            while (!in_ready && n < 100) begin @(negedge clk); n++; end
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                check("in_ready_wait", in_ready, 1);
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        @(posedge clk);
        exp_q.push_back({BASE - STEP * k, d});
        k++;
        #1;
    endtask

    task automatic wait_done(input int budget);
        int s;
        int n;
        s = done_cnt;
        n = 0;
        while (done_cnt == s && n < budget) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt - s, 1);
        check("busy_after_done", busy, 0);
        check("sb_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_en", mem_enable, 0);
        check("rst_mem_we", mem_write_enable, 0);
        check("rst_addr", mem_address, BASE);
        check("rst_data", mem_input_data, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words", words_written, 0);
        check("rst_state", state_dbg, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        // count = 0: straight to DONE, no write
        do_start(10'd0);
        check("z_done", done, 1);
        check("z_busy", busy, 1);
        check("z_hold_eq_busy", cpu_hold, busy);
        check("z_mem_en", mem_enable, 0);
        check("z_words", words_written, 0);
        @(posedge clk); #1;
        check("z_done_low", done, 0);
        check("z_idle", busy, 0);
        check("z_writes", load_writes, 0);

        // count = 8, in_valid held high
        chk_rate = 1;
        do_start(10'd8);
        check("l8_hold", cpu_hold, 1);
        for (int i = 1; i <= 8; i++) feed(i, 0);
        in_valid = 1'b0;
        wait_done(50);
        chk_rate = 0;
        check("l8_words", words_written, 8);
        check("l8_writes", load_writes, 8);
        check("l8_read_4064", mem_model.exists(32'd4064) ? mem_model[32'd4064] : 32'hdead, 8);

        // count = 3 with idle gaps before each word
        do_start(10'd3);
        for (int i = 0; i < 3; i++) feed($urandom_range(32'h7fff_ffff, 1), 5);
        in_valid = 1'b0;
        wait_done(50);
        check("l3_writes", load_writes, 3);
        check("l3_last_addr", last_addr, 4084);

        // second start during a count = 4 load is ignored
        do_start(10'd4);
        feed(32'ha1, 0);
        feed(32'ha2, 0);
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b1; count = 10'd8;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        feed(32'ha3, 0);
        feed(32'ha4, 0);
        in_valid = 1'b0;
        wait_done(50);
        check("l4_writes", load_writes, 4);
        check("l4_words", words_written, 4);

        // reset after the second write of a count = 8 load
        do_start(10'd8);
        feed(32'hb1, 0);
        feed(32'hb2, 0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hbad0;
        repeat (20) @(negedge clk);
        in_valid = 1'b0;
        check("rs_writes", load_writes, 2);
        check("rs_words", words_written, 0);
        check("rs_mem_kept", mem_model.exists(32'd4088) ? mem_model[32'd4088] : 32'hdead, 32'hb2);

        // count = 1023: full range down to address 4
        do_start(10'd1023);
        for (int i = 0; i < 1023; i++) feed($urandom, 0);
        in_valid = 1'b0;
        wait_done(50);
        check("big_words", words_written, 1023);
        check("big_writes", load_writes, 1023);
        check("big_last_addr", last_addr, 4);
        repeat (3) @(negedge clk);
        check("big_words_hold", words_written, 1023);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
